// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a multiplexed active-low 4-digit 7-segment scan into committed digit values; define SEG_SCAN_DECODER_DP_EN to capture decimal points
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic       decimal,
  input  logic       S0_enable,
  input  logic       S1_enable,
  input  logic       S2_enable,
  input  logic       S3_enable,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] dp,
  output logic [3:0] digit_err,
  output logic       frame_done,
  output logic       enable_err
);
  localparam logic [7:0] SAT  = 8'(STABLE_CYCLES);
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);
  logic [11:0] s1, s2, prev;
  logic [2:0]  vld;
  logic [7:0]  cnt, cnt_nxt;
  logic [3:0]  low, seen;
  logic [4:0]  dec;
  logic        at_end, one_low, commit, multi;
  logic [3:0]  dv [4];

  function automatic logic [4:0] decode(input logic [6:0] g);
    case (g)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      default:    decode = 5'h1F;
    endcase
  endfunction

  // two-flop synchronizer, previous-sample register, and a shift marking which stages hold post-reset data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 12'h0;
      s2   <= 12'h0;
      prev <= 12'h0;
      vld  <= 3'h0;
    end else begin
      s1   <= {seg, decimal, S3_enable, S2_enable, S1_enable, S0_enable};
      s2   <= s1;
      prev <= s2;
      vld  <= {vld[1:0], 1'b1};
    end
  end

  // stability run length, commit qualification and glyph decode of the current sample
  always_comb begin
    cnt_nxt = (!vld[2] || s2 != prev) ? 8'd0 : (cnt == SAT ? cnt : cnt + 8'd1);
    at_end  = vld[1] && cnt_nxt == LAST;
    low     = ~s2[3:0];
    one_low = low != 4'h0 && (low & (low - 4'd1)) == 4'h0;
    commit  = at_end && one_low;
    multi   = at_end && !one_low && low != 4'h0;
    dec     = decode(s2[11:5]);
  end

  // stability counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= 8'd0;
    else       cnt <= cnt_nxt;
  end

  // per-digit value and glyph error, written only for the enabled digit on a commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) dv[n] <= 4'h0;
      digit_err <= 4'h0;
    end else if (commit) begin
      for (int n = 0; n < 4; n++) if (low[n]) dv[n] <= dec[3:0];
      digit_err <= (digit_err & ~low) | (low & {4{dec[4]}});
    end
  end

`ifdef SEG_SCAN_DECODER_DP_EN
  // decimal point (active-low line) latched alongside each digit commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       dp <= 4'h0;
    else if (commit) dp <= (dp & ~low) | (low & {4{~s2[4]}});
  end
`else
  assign dp = 4'h0;
`endif

  // frame tracking pulses one clock after the mask fills, then restarts it; enable errors are sticky
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen       <= 4'h0;
      frame_done <= 1'b0;
      enable_err <= 1'b0;
    end else begin
      frame_done <= seen == 4'hF;
      seen       <= (seen == 4'hF ? 4'h0 : seen) | (commit ? low : 4'h0);
      enable_err <= enable_err | multi;
    end
  end

  assign d0 = dv[0];
  assign d1 = dv[1];
  assign d2 = dv[2];
  assign d3 = dv[3];
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: run-length reference model plus directed scan scenarios for seg_scan_decoder
module tb_seg_scan_decoder;
  localparam int S = 4;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg = 7'h7F;
  logic       decimal = 1'b1;
  logic       S0_enable = 1'b1, S1_enable = 1'b1, S2_enable = 1'b1, S3_enable = 1'b1;
  logic [3:0] d0, d1, d2, d3, dp, digit_err;
  logic       frame_done, enable_err;
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int p0;
  logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [11:0] hist [0:4095];
  int t = 0;
  logic [3:0] m_d [4];
  logic [3:0] m_err = 4'h0, m_dp = 4'h0, m_seen = 4'h0;
  logic       m_fd = 1'b0, m_ee = 1'b0;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .seg(seg), .decimal(decimal),
    .S0_enable(S0_enable), .S1_enable(S1_enable), .S2_enable(S2_enable), .S3_enable(S3_enable),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp(dp), .digit_err(digit_err),
    .frame_done(frame_done), .enable_err(enable_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] g);
    logic [4:0] r;
    r = 5'h1F;
    for (int v = 0; v < 10; v++) if (g == glyph[v]) r = {1'b0, 4'(v)};
    return r;
  endfunction

  // reference: a digit commits two clocks after its input value has been seen for exactly S consecutive post-reset edges
  always @(posedge clk) begin
    if (reset) begin
      t = 0;
      for (int n = 0; n < 4; n++) m_d[n] = 4'h0;
      m_err = 4'h0; m_dp = 4'h0; m_seen = 4'h0; m_fd = 1'b0; m_ee = 1'b0;
    end else begin
      int run;
      logic [11:0] smp;
      logic [3:0] lows;
      logic [4:0] r;
      if (t < 4095) t++;
      hist[t] = {seg, decimal, S3_enable, S2_enable, S1_enable, S0_enable};
      m_fd = (m_seen == 4'hF);
      if (m_fd) m_seen = 4'h0;
      if (t >= 3) begin
        run = 1;
        for (int k = t - 3; k >= 1 && hist[k] == hist[t-2] && run <= S; k--) run++;
        if (run == S) begin
          smp = hist[t-2];
          lows = ~smp[3:0];
          r = ref_decode(smp[11:5]);
          if ($countones(lows) == 1) begin
            for (int n = 0; n < 4; n++) if (lows[n]) begin
              m_d[n] = r[3:0];
              m_err[n] = r[4];
`ifdef SEG_SCAN_DECODER_DP_EN
              m_dp[n] = ~smp[4];
`endif
              m_seen[n] = 1'b1;
            end
          end else if ($countones(lows) >= 2) m_ee = 1'b1;
        end
      end
    end
  end

  // cycle-by-cycle comparison against the reference
  always @(posedge clk) begin
    #1;
    chk("d0", int'(d0), int'(m_d[0]));
    chk("d1", int'(d1), int'(m_d[1]));
    chk("d2", int'(d2), int'(m_d[2]));
    chk("d3", int'(d3), int'(m_d[3]));
    chk("digit_err", int'(digit_err), int'(m_err));
    chk("dp", int'(dp), int'(m_dp));
    chk("frame_done", int'(frame_done), int'(m_fd));
    chk("enable_err", int'(enable_err), int'(m_ee));
    if (frame_done) pulses++;
  end

  task automatic drive(input logic [6:0] s, input logic dpl, input logic [3:0] en, input int n);
    @(negedge clk);
    seg = s;
    decimal = dpl;
    {S3_enable, S2_enable, S1_enable, S0_enable} = en;
    repeat (n) @(posedge clk);
  endtask

  task automatic scan(input int n, input int g);
    drive(glyph[g], 1'b1, 4'hF ^ (4'h1 << n), 8);
    drive(7'h7F, 1'b1, 4'hF, 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_digits", int'({d3, d2, d1, d0}), 0);
    chk("rst_flags", int'({dp, digit_err, frame_done, enable_err}), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("init_digits", int'({d3, d2, d1, d0}), 0);
    chk("init_flags", int'({dp, digit_err, frame_done, enable_err}), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(7'h7F, 1'b1, 4'hF, 4);
    // single digit latency
    drive(glyph[3], 1'b1, 4'b1011, 5);
    #1 chk("lat_before", int'(d2), 0);
    @(posedge clk);
    #1;
    chk("lat_d2", int'(d2), 3);
    chk("lat_err", int'(digit_err), 0);
    chk("lat_others", int'({d3, d1, d0}), 0);
    repeat (4) @(posedge clk);
    // illegal glyph then recovery
    drive(7'b1010101, 1'b1, 4'b1101, 8);
    #1 chk("bad_d1", int'(d1), 15);
    chk("bad_err", int'(digit_err[1]), 1);
    drive(glyph[7], 1'b1, 4'b1101, 8);
    #1 chk("fix_d1", int'(d1), 7);
    chk("fix_err", int'(digit_err[1]), 0);
    drive(7'h7F, 1'b1, 4'b1110, 8);
    #1 chk("blank_d0", int'(d0), 15);
    chk("blank_err", int'(digit_err[0]), 1);
    drive(7'h7F, 1'b1, 4'hF, 2);
    // full frame scans
    do_reset();
    p0 = pulses;
    for (int n = 0; n < 4; n++) scan(n, n + 1);
    chk("scan_digits", int'({d3, d2, d1, d0}), 16'h4321);
    chk("scan_pulses", pulses - p0, 1);
    scan(0, 5);
    scan(0, 6);
    scan(1, 7);
    scan(2, 8);
    chk("partial_pulses", pulses - p0, 1);
    scan(3, 9);
    chk("second_pulses", pulses - p0, 2);
    // two enables low
    drive(glyph[8], 1'b1, 4'b0110, 8);
    #1 chk("multi_ee", int'(enable_err), 1);
    chk("multi_d0", int'(d0), 6);
    chk("multi_d3", int'(d3), 9);
    scan(0, 0);
    chk("sticky_ee", int'(enable_err), 1);
    chk("sticky_d0", int'(d0), 0);
    do_reset();
    // glitching segments never commit
    for (int i = 0; i < 6; i++) drive(glyph[(i % 2) + 1], 1'b1, 4'b1110, 2);
    chk("glitch_d0", int'(d0), 0);
    // reset two clocks into a stable interval
    drive(glyph[3], 1'b1, 4'b1110, 2);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("mid_rst_d0", int'(d0), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("post_rst_early", int'(d0), 0);
    @(posedge clk);
    #1 chk("post_rst_d0", int'(d0), 3);
    // decimal point capture
    drive(glyph[5], 1'b0, 4'b0111, 8);
    #1 chk("dp_d3", int'(d3), 5);
`ifdef SEG_SCAN_DECODER_DP_EN
    chk("dp_val", int'(dp), 8);
`else
    chk("dp_val", int'(dp), 0);
`endif
    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, meaning consecutive identical synchronized samples required before a digit commits (legal range 1..255).
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 seg  input  7  segment lines {g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-005 decimal  input  1  decimal-point line, active-low.
REQ-006 S0_enable, S1_enable, S2_enable, S3_enable  input  1 each  digit enables, active-low; S0 = least significant digit.
REQ-007 d0, d1, d2, d3  output  4 each  last committed value of digit 0..3.
REQ-008 dp  output  4  last committed decimal-point state per digit, 1 = lit.
REQ-009 digit_err  output  4  per digit, 1 = last committed pattern was not a legal 0-9 glyph.
REQ-010 frame_done  output  1  single-cycle pulse when all four digits have committed since the previous pulse.
REQ-011 enable_err  output  1  sticky flag for illegal enable combinations.

Function
REQ-012 All inputs pass through a 2-flop synchronizer; all logic below uses the synchronized copies.
REQ-013 Legal glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-014 A stability counter resets to 0 whenever the synchronized {seg, decimal, enables} differs from the previous sample; otherwise it increments, saturating at STABLE_CYCLES.
REQ-015 A commit occurs on the cycle the counter reaches STABLE_CYCLES-1 with exactly one enable low; one commit per stable interval.
REQ-016 Latency: input change to updated output = STABLE_CYCLES+2 clocks.
REQ-017 On commit to digit n: dn = decoded value, digit_err[n] = 0 for a legal glyph; for any other pattern (including blank 1111111) dn = 4'hF, digit_err[n] = 1.
REQ-018 Enables all high: no commit, no error (inter-digit blanking).
REQ-019 Two or more enables low for a full stable interval: no commit, enable_err sets and holds until reset.
REQ-020 A 4-bit seen mask sets bit n on each commit to digit n; repeat commits to the same digit have no additional effect.
REQ-021 When the mask becomes 1111, frame_done pulses for one cycle in the following clock and the mask clears.
REQ-022 A commit in the same cycle the mask clears sets only its own bit in the new mask.
REQ-023 Non-committed digits hold their output values indefinitely.

Reset
REQ-024 Reset asynchronously clears the synchronizers, counter and seen mask.
REQ-025 During reset: d0-d3 = 4'h0, dp = 0, digit_err = 0, frame_done = 0, enable_err = 0.
REQ-026 Reset mid-interval discards the partial stability count; no commit occurs until a full new interval after release.

Configuration
REQ-027 Macro SEG_SCAN_DECODER_DP_EN defined: dp[n] = inverted synchronized decimal captured at each commit to digit n.
REQ-028 Macro undefined: no decimal capture logic; dp is constant 0 and decimal is unused.

Verification
REQ-029 STABLE_CYCLES=4; S2_enable low, seg=0110000, held 10 clocks -> d2=3 and digit_err[2]=0 exactly 6 clocks after the change; other digits unchanged.
REQ-030 Scan digits 0..3 with glyphs 1,2,3,4, each held 8 clocks with 2 blank clocks between -> d0..d3 = 1,2,3,4; one frame_done pulse after the 4th commit; no second pulse until 4 more distinct commits.
REQ-031 S1_enable low, seg=1010101 held 8 clocks -> d1=4'hF, digit_err[1]=1; then glyph 7 -> d1=7, digit_err[1]=0.
REQ-032 S0_enable and S3_enable both low, held 8 clocks -> enable_err=1, d0 and d3 unchanged; enable_err stays 1 through later legal scans until reset.
REQ-033 Glitch: seg toggles every 2 clocks with STABLE_CYCLES=4 -> no commit; reset asserted 2 clocks into a stable interval -> all outputs 0, commit only after 4+2 clocks post-release.
REQ-034 With SEG_SCAN_DECODER_DP_EN, S3_enable low, decimal=0, glyph 5 -> d3=5, dp[3]=1; without the macro -> dp=0.
